// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store,
// producing the pipeline stall and guarding the memory handshake with a watchdog.
module unified_mem_arbiter #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    input  logic              flush,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err,
    output logic [1:0]        dbg_state
);

    // Memory handshake: mem_req rises on the edge after issue and, together with
    // mem_we/mem_addr/mem_wdata, stays stable until the first edge with
    // mem_req & mem_ready; mem_ready is ignored while mem_req is low.

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DATA_BUSY  = 2'd1,
        FETCH_BUSY = 2'd2,
        FETCH_DROP = 2'd3
    } state_t;

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                if_done_q, if_done_d;
    logic                d_done_q, d_done_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic d_pend, f_pend, complete, expire;

    assign d_pend   = (d_rd | d_wr) & ~d_done_q;
    assign f_pend   = if_req & ~if_done_q;
    assign stall    = (state_q != IDLE) | d_pend | f_pend;
    assign complete = mem_req_q & mem_ready;
    // Completion on the expiry edge takes precedence over the timeout.
    assign expire   = (TIMEOUT != 0) && mem_req_q && !mem_ready && (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_done_d   = if_done_q;
        d_done_d    = d_done_q;
        err_d       = err_q;
        cnt_d       = cnt_q;

        if (!stall) begin
            if_done_d = 1'b0;
            d_done_d  = 1'b0;
        end
        if (flush) begin
            if_done_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (d_pend) begin
                    state_d     = DATA_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_wr;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    cnt_d       = '0;
                end else if (f_pend && !flush) begin
                    state_d    = FETCH_BUSY;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    cnt_d      = '0;
                end
            end
            DATA_BUSY: begin
                if (complete) begin
                    mem_req_d = 1'b0;
                    d_done_d  = 1'b1;
                    state_d   = IDLE;
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end else if (expire) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    d_done_d  = 1'b1;
                    d_rdata_d = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FETCH_BUSY: begin
                // A flush landing on the completing edge still discards the word.
                if (complete) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    if (!flush) begin
                        if_rdata_d = mem_rdata;
                        if_done_d  = 1'b1;
                    end
                end else if (expire) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                    if (!flush) begin
                        if_rdata_d = '0;
                        if_done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (flush) begin
                        state_d = FETCH_DROP;
                    end
                end
            end
            FETCH_DROP: begin
                if (complete) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end else if (expire) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_done_q;
    assign d_rdata   = d_rdata_q;
    assign d_valid   = d_done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: per-cycle vector table plus
// hand-written watchdog and asynchronous-reset sequences.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic [15:0] if_rdata;
    logic        if_valid;
    logic        d_rd = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic [15:0] d_rdata;
    logic        d_valid;
    logic        flush = 1'b0;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        err;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .flush(flush), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .err(err), .dbg_state(dbg_state)
    );

    typedef struct packed {
        logic        if_req;
        logic [15:0] if_addr;
        logic        d_rd;
        logic        d_wr;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic        flush;
        logic        mem_ready;
        logic [15:0] mem_rdata;
    } in_t;

    typedef struct packed {
        logic        stall;
        logic        mem_req;
        logic        mem_we;
        logic [15:0] mem_addr;
        logic [15:0] mem_wdata;
        logic        if_valid;
        logic [15:0] if_rdata;
        logic        d_valid;
        logic [15:0] d_rdata;
        logic        err;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t vecs[$];

    function automatic in_t vi(logic ifr, logic [15:0] ifa, logic rd, logic wr,
                               logic [15:0] da, logic [15:0] dw, logic fl,
                               logic rdy, logic [15:0] rdat);
        in_t r;
        r.if_req = ifr; r.if_addr = ifa; r.d_rd = rd; r.d_wr = wr;
        r.d_addr = da; r.d_wdata = dw; r.flush = fl;
        r.mem_ready = rdy; r.mem_rdata = rdat;
        return r;
    endfunction

    function automatic out_t vo(logic st, logic rq, logic we, logic [15:0] ad,
                                logic [15:0] wd, logic iv, logic [15:0] ir,
                                logic dv, logic [15:0] dr, logic er);
        out_t r;
        r.stall = st; r.mem_req = rq; r.mem_we = we; r.mem_addr = ad;
        r.mem_wdata = wd; r.if_valid = iv; r.if_rdata = ir;
        r.d_valid = dv; r.d_rdata = dr; r.err = er;
        return r;
    endfunction

    function automatic out_t sample();
        return vo(stall, mem_req, mem_we, mem_addr, mem_wdata,
                  if_valid, if_rdata, d_valid, d_rdata, err);
    endfunction

    task automatic drive(in_t v);
        if_req    = v.if_req;
        if_addr   = v.if_addr;
        d_rd      = v.d_rd;
        d_wr      = v.d_wr;
        d_addr    = v.d_addr;
        d_wdata   = v.d_wdata;
        flush     = v.flush;
        mem_ready = v.mem_ready;
        mem_rdata = v.mem_rdata;
    endtask

    task automatic check(string name, logic [79:0] act, logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // fetch only
        vecs.push_back('{vi(1,16'h0010,0,0,16'h0000,16'h0000,0,0,16'h0000), vo(1,0,0,16'h0000,16'h0000,0,16'h0000,0,16'h0000,0)});
        vecs.push_back('{vi(1,16'h0010,0,0,16'h0000,16'h0000,0,1,16'hA5C3), vo(1,1,0,16'h0010,16'h0000,0,16'h0000,0,16'h0000,0)});
        vecs.push_back('{vi(1,16'h0010,0,0,16'h0000,16'h0000,0,0,16'h0000), vo(0,0,0,16'h0010,16'h0000,1,16'hA5C3,0,16'h0000,0)});
        vecs.push_back('{vi(0,16'h0000,0,0,16'h0000,16'h0000,0,0,16'h0000), vo(0,0,0,16'h0010,16'h0000,0,16'hA5C3,0,16'h0000,0)});
        // contention: data wins, two wait cycles, then fetch after one idle cycle
        vecs.push_back('{vi(1,16'h0020,1,0,16'h0200,16'h0000,0,0,16'h0000), vo(1,0,0,16'h0010,16'h0000,0,16'hA5C3,0,16'h0000,0)});
        vecs.push_back('{vi(1,16'h0020,1,0,16'h0200,16'h0000,0,0,16'h0000), vo(1,1,0,16'h0200,16'h0000,0,16'hA5C3,0,16'h0000,0)});
        vecs.push_back('{vi(1,16'h0020,1,0,16'h0200,16'h0000,0,0,16'h0000), vo(1,1,0,16'h0200,16'h0000,0,16'hA5C3,0,16'h0000,0)});
        vecs.push_back('{vi(1,16'h0020,1,0,16'h0200,16'h0000,0,1,16'h5A5A), vo(1,1,0,16'h0200,16'h0000,0,16'hA5C3,0,16'h0000,0)});
        vecs.push_back('{vi(1,16'h0020,1,0,16'h0200,16'h0000,0,0,16'h0000), vo(1,0,0,16'h0200,16'h0000,0,16'hA5C3,1,16'h5A5A,0)});
        vecs.push_back('{vi(1,16'h0020,1,0,16'h0200,16'h0000,0,1,16'h1111), vo(1,1,0,16'h0020,16'h0000,0,16'hA5C3,1,16'h5A5A,0)});
        vecs.push_back('{vi(1,16'h0020,1,0,16'h0200,16'h0000,0,0,16'h0000), vo(0,0,0,16'h0020,16'h0000,1,16'h1111,1,16'h5A5A,0)});
        vecs.push_back('{vi(0,16'h0000,0,0,16'h0000,16'h0000,0,0,16'h0000), vo(0,0,0,16'h0020,16'h0000,0,16'h1111,0,16'h5A5A,0)});
        // store with three wait cycles; d_rdata must not change
        vecs.push_back('{vi(0,16'h0000,0,1,16'h0300,16'h1234,0,0,16'h0000), vo(1,0,0,16'h0020,16'h0000,0,16'h1111,0,16'h5A5A,0)});
        vecs.push_back('{vi(0,16'h0000,0,1,16'h0300,16'h1234,0,0,16'h0000), vo(1,1,1,16'h0300,16'h1234,0,16'h1111,0,16'h5A5A,0)});
        vecs.push_back('{vi(0,16'h0000,0,1,16'h0300,16'h1234,0,0,16'h0000), vo(1,1,1,16'h0300,16'h1234,0,16'h1111,0,16'h5A5A,0)});
        vecs.push_back('{vi(0,16'h0000,0,1,16'h0300,16'h1234,0,0,16'h0000), vo(1,1,1,16'h0300,16'h1234,0,16'h1111,0,16'h5A5A,0)});
        vecs.push_back('{vi(0,16'h0000,0,1,16'h0300,16'h1234,0,1,16'hDEAD), vo(1,1,1,16'h0300,16'h1234,0,16'h1111,0,16'h5A5A,0)});
        vecs.push_back('{vi(0,16'h0000,0,1,16'h0300,16'h1234,0,0,16'h0000), vo(0,0,1,16'h0300,16'h1234,0,16'h1111,1,16'h5A5A,0)});
        vecs.push_back('{vi(0,16'h0000,0,0,16'h0000,16'h0000,0,0,16'h0000), vo(0,0,1,16'h0300,16'h1234,0,16'h1111,0,16'h5A5A,0)});
        // flush while a fetch waits: word dropped, new fetch served afterwards
        vecs.push_back('{vi(1,16'h0040,0,0,16'h0000,16'h0000,0,0,16'h0000), vo(1,0,1,16'h0300,16'h1234,0,16'h1111,0,16'h5A5A,0)});
        vecs.push_back('{vi(1,16'h0040,0,0,16'h0000,16'h0000,1,0,16'h0000), vo(1,1,0,16'h0040,16'h1234,0,16'h1111,0,16'h5A5A,0)});
        vecs.push_back('{vi(1,16'h0080,0,0,16'h0000,16'h0000,0,0,16'h0000), vo(1,1,0,16'h0040,16'h1234,0,16'h1111,0,16'h5A5A,0)});
        vecs.push_back('{vi(1,16'h0080,0,0,16'h0000,16'h0000,0,1,16'hBEEF), vo(1,1,0,16'h0040,16'h1234,0,16'h1111,0,16'h5A5A,0)});
        vecs.push_back('{vi(1,16'h0080,0,0,16'h0000,16'h0000,0,0,16'h0000), vo(1,0,0,16'h0040,16'h1234,0,16'h1111,0,16'h5A5A,0)});
        vecs.push_back('{vi(1,16'h0080,0,0,16'h0000,16'h0000,0,1,16'hCAFE), vo(1,1,0,16'h0080,16'h1234,0,16'h1111,0,16'h5A5A,0)});
        vecs.push_back('{vi(1,16'h0080,0,0,16'h0000,16'h0000,0,0,16'h0000), vo(0,0,0,16'h0080,16'h1234,1,16'hCAFE,0,16'h5A5A,0)});
        // mem_ready while idle is ignored
        vecs.push_back('{vi(0,16'h0000,0,0,16'h0000,16'h0000,0,1,16'h9999), vo(0,0,0,16'h0080,16'h1234,0,16'hCAFE,0,16'h5A5A,0)});
        vecs.push_back('{vi(0,16'h0000,0,0,16'h0000,16'h0000,0,0,16'h0000), vo(0,0,0,16'h0080,16'h1234,0,16'hCAFE,0,16'h5A5A,0)});

        // reset state, applied asynchronously before any clock edge
        #1 rst = 1'b1;
        #1;
        check("reset_outputs", 80'(sample()), 80'(vo(0,0,0,16'h0,16'h0,0,16'h0,0,16'h0,0)));
        check("reset_state", 80'(dbg_state), 80'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].i);
            #1;
            check($sformatf("vec%0d", k), 80'(sample()), 80'(vecs[k].o));
        end

        // watchdog: memory never answers a load
        @(negedge clk);
        drive(vi(0,16'h0000,1,0,16'h0400,16'h0000,0,0,16'h0000));
        #1;
        check("wd_issue_stall", 80'(stall), 80'd1);
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            #1;
            check($sformatf("wd_req_hold%0d", w), 80'({mem_req, mem_addr}), 80'({1'b1, 16'h0400}));
        end
        @(negedge clk);
        #1;
        check("wd_expire", 80'({mem_req, err, d_valid, d_rdata, stall}),
              80'({1'b0, 1'b1, 1'b1, 16'h0000, 1'b0}));
        check("wd_state_idle", 80'(dbg_state), 80'd0);
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            drive(vi(0,16'h0000,0,0,16'h0000,16'h0000,0,0,16'h0000));
            #1;
            check($sformatf("wd_err_sticky%0d", w), 80'({err, d_valid, mem_req}), 80'({1'b1, 1'b0, 1'b0}));
        end

        // asynchronous reset in the middle of a data access
        @(negedge clk);
        drive(vi(0,16'h0000,1,0,16'h0500,16'h0000,0,0,16'h0000));
        @(posedge clk);
        #2;
        check("ar_busy_before", 80'({mem_req, dbg_state}), 80'({1'b1, 2'd1}));
        rst = 1'b1;
        #1;
        check("ar_cleared", 80'({mem_req, err, d_valid, if_valid, dbg_state, mem_addr}),
              80'({1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000}));
        @(negedge clk);
        rst = 1'b0;
        drive(vi(0,16'h0000,1,0,16'h0600,16'h0000,0,0,16'h0000));
        #1;
        check("ar_fresh_req", 80'({stall, mem_req}), 80'({1'b1, 1'b0}));
        @(negedge clk);
        drive(vi(0,16'h0000,1,0,16'h0600,16'h0000,0,1,16'h7777));
        #1;
        check("ar_fresh_issue", 80'({mem_req, mem_we, mem_addr}), 80'({1'b1, 1'b0, 16'h0600}));
        @(negedge clk);
        drive(vi(0,16'h0000,1,0,16'h0600,16'h0000,0,0,16'h0000));
        #1;
        check("ar_fresh_done", 80'({d_valid, d_rdata, stall, err, mem_req}),
              80'({1'b1, 16'h7777, 1'b0, 1'b0, 1'b0}));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between the fetch stage (instruction reads) and the memory stage (opcode 0111 load / 1000 store).
- Sequences each access over a req/ready memory handshake and raises the pipeline stall that feeds the control unit.
- Discards in-flight fetches on pipeline flush.
- Provides a watchdog so a non-responding memory cannot hang the core.

Parameters:
ADDR_W, 16, address width.
DATA_W, 16, data width.
TIMEOUT, 64, max cycles mem_req may wait for mem_ready; 0 disables the watchdog.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
if_req  input  1  fetch read request, level, held until served.
if_addr  input  ADDR_W  fetch address.
if_rdata  output  DATA_W  fetched word, registered.
if_valid  output  1  fetch served; if_rdata valid.
d_rd  input  1  load request (MemRead), level.
d_wr  input  1  store request (MemWrite), level.
d_addr  input  ADDR_W  data address.
d_wdata  input  DATA_W  store data.
d_rdata  output  DATA_W  load result, registered.
d_valid  output  1  data access served.
flush  input  1  pipeline flush (taken branch/jump).
stall  output  1  pipeline stall to control unit/hazard logic.
mem_req  output  1  memory request, registered.
mem_we  output  1  1 = write.
mem_addr  output  ADDR_W  memory address.
mem_wdata  output  DATA_W  memory write data.
mem_ready  input  1  memory accepts/completes; read data valid same cycle.
mem_rdata  input  DATA_W  memory read data.
err  output  1  sticky watchdog error.

Behaviour:
- Reset (async, immediate): state IDLE; mem_req, mem_we, err, if_valid, d_valid, internal done flags = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0; timeout counter = 0.
- States: IDLE, DATA_BUSY, FETCH_BUSY, FETCH_DROP.
- Served flags d_done and if_done drive d_valid and if_valid directly (level).
  - Set on completion of the matching access.
  - Both cleared on any cycle with stall=0 (pipeline advance).
  - if_done is also cleared when flush=1.
- Pending conditions:
  - data pending = (d_rd|d_wr) & ~d_done.
  - fetch pending = if_req & ~if_done.
- stall (combinational) = (state != IDLE) | data pending | fetch pending.
- IDLE issue rules:
  - Data pending → DATA_BUSY. Data has priority, being the older instruction.
  - Otherwise, fetch pending & ~flush → FETCH_BUSY.
  - On the issue edge, register mem_req=1, mem_we=d_wr (0 for fetch), mem_addr, mem_wdata.
- Simultaneous d_rd and d_wr: treated as a write.
- Busy states:
  - mem_req/mem_we/mem_addr/mem_wdata held stable until the edge where mem_req & mem_ready.
  - On that edge: mem_req←0; for reads, capture mem_rdata into d_rdata or if_rdata; set the done flag; → IDLE.
- Latency:
  - Request seen in IDLE at cycle N → mem_req high at N+1.
  - If mem_ready at N+1 → valid and stall low at N+2.
  - Minimum one IDLE cycle between transactions.
- Stores leave d_rdata unchanged.
- Flush:
  - flush in FETCH_BUSY → FETCH_DROP. The request is kept until mem_ready; then the data is discarded, if_done stays 0, → IDLE.
  - flush in FETCH_DROP: no effect.
  - flush never affects DATA_BUSY or d_done.
- Watchdog (TIMEOUT>0):
  - Counter clears on issue and increments each cycle mem_req & ~mem_ready.
  - When it reaches TIMEOUT: mem_req←0, err←1 (sticky until rst), done flag of the owning requester set with its rdata←0, → IDLE.
  - No done flag is set in FETCH_DROP.
  - mem_ready on the same edge as expiry wins: normal completion, no err.
- Reset mid-transaction: mem_req drops asynchronously. The memory must tolerate an abandoned request.
- While mem_ready is asserted and mem_req=0, mem_ready is ignored.

Test Plan:
- Fetch only: if_req=1, if_addr=0x0010, mem_ready=1 the first cycle mem_req is high, mem_rdata=0xA5C3 → mem_req high 1 cycle with mem_we=0; if_valid=1, if_rdata=0xA5C3, stall=0 exactly 2 cycles after request.
- Contention: if_req and d_rd (d_addr=0x0200) asserted together, memory ready after 2 wait cycles → data served first (d_rdata=mem_rdata@0x0200); then after one IDLE cycle, fetch issued; stall high throughout until both done.
- Store: d_wr=1, d_addr=0x0300, d_wdata=0x1234 → mem_we=1, mem_addr=0x0300, mem_wdata=0x1234 stable across 3 wait cycles; d_valid set; d_rdata unchanged.
- Flush drop: fetch to 0x0040 in flight, flush pulsed during wait → request held until mem_ready; if_valid stays 0; a new if_req to 0x0080 is issued afterwards and served.
- Watchdog with TIMEOUT=4, mem_ready held 0 → mem_req drops after 4 wait cycles; err=1; d_valid=1 with d_rdata=0; err persists until rst.
- Async reset asserted mid DATA_BUSY → mem_req, stall-related flags, and err cleared without a clock edge; after reset release, a fresh request proceeds normally.
